// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings, scoreboard entry and match helper
// for the pipeline hazard controller.
package hazard_pkg;

    // Widest register index the scoreboard can hold.
    localparam int HZ_REG_MAX = 8;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_STALL = 2'b01,
        ST_MEM_WAIT = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_e;

    localparam logic [HZ_REG_MAX-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic [HZ_REG_MAX-1:0] rs;
        logic [HZ_REG_MAX-1:0] rt;
        logic                  uses_rs;
        logic                  uses_rt;
        logic [HZ_REG_MAX-1:0] dest;
        logic                  reg_write;
        logic                  mem_read;
    } sb_entry_t;

    // Entry e will write register r, and r is not the hardwired zero.
    function automatic logic hz_match(
        sb_entry_t             e,
        logic [HZ_REG_MAX-1:0] r
    );
        return e.valid & e.reg_write &
               (e.dest == r) & (r != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// hazard_sat_counter: enable-driven event counter that sticks
// at all-ones instead of wrapping.
module hazard_sat_counter
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_max;

    assign at_max = &cnt_q;

    // Next count: bump on enable unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i && !at_max) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: load-use stall, branch flush, memory freeze
// and EX operand forwarding for the 5-stage pipeline.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int REG_W            = 5,
    parameter int CNT_W            = 16,
    parameter bit RF_WRITE_THROUGH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             stall,
    output logic             bubble,
    output logic             flush,
    output logic             freeze,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    sb_entry_t ex_q;
    sb_entry_t ex_d;
    sb_entry_t mem_q;
    sb_entry_t wb_q;
    sb_entry_t id_ent;
    state_e    state_q;

    logic [HZ_REG_MAX-1:0] rs_x;
    logic [HZ_REG_MAX-1:0] rt_x;
    logic                  lu;
    logic                  freeze_w;
    logic                  flush_w;
    logic                  stall_w;
    fwd_e                  fwd_a_w;
    fwd_e                  fwd_b_w;
    logic                  unused_sb;

    // Register indices widened to the scoreboard field width.
    assign rs_x = HZ_REG_MAX'(id_rs);
    assign rt_x = HZ_REG_MAX'(id_rt);

    // Pack the decoded ID instruction into a scoreboard entry.
    always_comb begin
        id_ent           = '0;
        id_ent.valid     = id_valid;
        id_ent.rs        = rs_x;
        id_ent.rt        = rt_x;
        id_ent.uses_rs   = id_uses_rs;
        id_ent.uses_rt   = id_uses_rt;
        id_ent.dest      = HZ_REG_MAX'(id_dest);
        id_ent.reg_write = id_reg_write;
        id_ent.mem_read  = id_mem_read;
    end

    // Load in EX feeding a source the ID instruction reads.
    assign lu = id_valid & ex_q.mem_read &
                ((id_uses_rs & hz_match(ex_q, rs_x)) |
                 (id_uses_rt & hz_match(ex_q, rt_x)));

    // Reset forces every control output low at once.
    assign freeze_w = mem_busy & ~rst;
    assign flush_w  = ex_branch_taken & ~freeze_w & ~rst;
    assign stall_w  = lu & ~ex_branch_taken &
                      ~freeze_w & ~rst;

    assign stall  = stall_w;
    assign bubble = stall_w;
    assign flush  = flush_w;
    assign freeze = freeze_w;

    // Entry entering EX: squashed on bubble, flush or empty ID.
    always_comb begin
        ex_d = id_ent;
        if (stall_w || flush_w || !id_valid) begin
            ex_d = '0;
        end
    end

    // Shadow scoreboard advances unless memory freezes the pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!freeze_w) begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    // Operand selects for the instruction in EX; MEM beats WB.
    always_comb begin
        fwd_a_w = FWD_RF;
        fwd_b_w = FWD_RF;
        if (ex_q.valid && ex_q.uses_rs) begin
            if (hz_match(mem_q, ex_q.rs)) begin
                fwd_a_w = FWD_MEM;
            end else if (!RF_WRITE_THROUGH &&
                         hz_match(wb_q, ex_q.rs)) begin
                fwd_a_w = FWD_WB;
            end
        end
        if (ex_q.valid && ex_q.uses_rt) begin
            if (hz_match(mem_q, ex_q.rt)) begin
                fwd_b_w = FWD_MEM;
            end else if (!RF_WRITE_THROUGH &&
                         hz_match(wb_q, ex_q.rt)) begin
                fwd_b_w = FWD_WB;
            end
        end
    end

    assign fwd_a = fwd_a_w;
    assign fwd_b = fwd_b_w;

    // Sequencing state: memory wait dominates, then load-use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            unique case (1'b1)
                mem_busy: state_q <= ST_MEM_WAIT;
                stall_w:  state_q <= ST_LU_STALL;
                default:  state_q <= ST_RUN;
            endcase
        end
    end

    assign state = state_q;

    hazard_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (stall_w),
        .count_o (stall_cnt)
    );

    hazard_sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (flush_w),
        .count_o (flush_cnt)
    );

    // Later-stage source fields are carried only for debug visibility.
    assign unused_sb = ^{wb_q, mem_q};

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: vector table plus directed sequences for
// stalls, flushes, freeze, forwarding, saturation and reset.
module tb_hazard_controller;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] dest;
        logic       rw;
        logic       mr;
    } instr_t;

    typedef struct {
        instr_t     ins;
        logic       br;
        logic       busy;
        logic       e_stall;
        logic       e_flush;
        logic       e_freeze;
        logic [1:0] e_fa;
        logic [1:0] e_fb;
        logic [1:0] e_fa1;
        logic [1:0] e_fb1;
        logic [1:0] e_st;
        int         e_sc;
        int         e_fc;
    } vec_t;

    localparam int NV = 41;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic [4:0] id_dest;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       ex_branch_taken;
    logic       mem_busy;

    logic        stall, bubble, flush, freeze;
    logic [1:0]  fwd_a, fwd_b, state;
    logic [15:0] stall_cnt, flush_cnt;

    logic        stall1, bubble1, flush1, freeze1;
    logic [1:0]  fwd_a1, fwd_b1, state1;
    logic [7:0]  stall_cnt1, flush_cnt1;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t   tab [NV];
    instr_t NOP, LW5, ADD6, ADD5, SUB8, LW0, ADD9;
    instr_t NOUSE, SW, LWDEP;

    always #5 clk = ~clk;

    hazard_controller #(
        .REG_W (5), .CNT_W (16), .RF_WRITE_THROUGH (1'b0)
    ) dut (
        .clk (clk), .rst (rst),
        .id_valid (id_valid), .id_rs (id_rs), .id_rt (id_rt),
        .id_uses_rs (id_uses_rs), .id_uses_rt (id_uses_rt),
        .id_dest (id_dest), .id_reg_write (id_reg_write),
        .id_mem_read (id_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy (mem_busy),
        .stall (stall), .bubble (bubble), .flush (flush),
        .freeze (freeze), .fwd_a (fwd_a), .fwd_b (fwd_b),
        .state (state), .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    hazard_controller #(
        .REG_W (5), .CNT_W (8), .RF_WRITE_THROUGH (1'b1)
    ) dut1 (
        .clk (clk), .rst (rst),
        .id_valid (id_valid), .id_rs (id_rs), .id_rt (id_rt),
        .id_uses_rs (id_uses_rs), .id_uses_rt (id_uses_rt),
        .id_dest (id_dest), .id_reg_write (id_reg_write),
        .id_mem_read (id_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy (mem_busy),
        .stall (stall1), .bubble (bubble1), .flush (flush1),
        .freeze (freeze1), .fwd_a (fwd_a1), .fwd_b (fwd_b1),
        .state (state1), .stall_cnt (stall_cnt1),
        .flush_cnt (flush_cnt1)
    );

    function automatic instr_t mki(
        logic v, logic [4:0] rs, logic [4:0] rt,
        logic urs, logic urt, logic [4:0] dest,
        logic rw, logic mr
    );
        instr_t i;
        i = '{v, rs, rt, urs, urt, dest, rw, mr};
        return i;
    endfunction

    function automatic vec_t mk(
        instr_t ins, logic br, logic busy,
        logic st, logic fl, logic fr,
        logic [1:0] fa, logic [1:0] fb,
        logic [1:0] fa1, logic [1:0] fb1,
        logic [1:0] s, int sc, int fc
    );
        vec_t t;
        t.ins = ins; t.br = br; t.busy = busy;
        t.e_stall = st; t.e_flush = fl; t.e_freeze = fr;
        t.e_fa = fa; t.e_fb = fb; t.e_fa1 = fa1; t.e_fb1 = fb1;
        t.e_st = s; t.e_sc = sc; t.e_fc = fc;
        return t;
    endfunction

    task automatic drive(instr_t i, logic br, logic busy);
        id_valid        = i.v;
        id_rs           = i.rs;
        id_rt           = i.rt;
        id_uses_rs      = i.urs;
        id_uses_rt      = i.urt;
        id_dest         = i.dest;
        id_reg_write    = i.rw;
        id_mem_read     = i.mr;
        ex_branch_taken = br;
        mem_busy        = busy;
    endtask

    task automatic chk(string nm, logic [31:0] act,
                       logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(string tag);
        chk({tag, " stall"},  32'(stall),     0);
        chk({tag, " bubble"}, 32'(bubble),    0);
        chk({tag, " flush"},  32'(flush),     0);
        chk({tag, " freeze"}, 32'(freeze),    0);
        chk({tag, " fwd_a"},  32'(fwd_a),     0);
        chk({tag, " fwd_b"},  32'(fwd_b),     0);
        chk({tag, " state"},  32'(state),     0);
        chk({tag, " scnt"},   32'(stall_cnt), 0);
        chk({tag, " fcnt"},   32'(flush_cnt), 0);
        chk({tag, " scnt1"},  32'(stall_cnt1), 0);
        chk({tag, " fcnt1"},  32'(flush_cnt1), 0);
    endtask

    initial begin
        NOP   = mki(0, 0, 0, 0, 0, 0, 0, 0);
        LW5   = mki(1, 1, 0, 1, 0, 5, 1, 1);
        ADD6  = mki(1, 5, 7, 1, 1, 6, 1, 0);
        ADD5  = mki(1, 1, 2, 1, 1, 5, 1, 0);
        SUB8  = mki(1, 5, 5, 1, 1, 8, 1, 0);
        LW0   = mki(1, 1, 0, 1, 0, 0, 1, 1);
        ADD9  = mki(1, 0, 0, 1, 1, 9, 1, 0);
        NOUSE = mki(1, 5, 5, 0, 0, 3, 1, 0);
        SW    = mki(1, 1, 5, 1, 1, 0, 0, 0);
        LWDEP = mki(1, 5, 0, 1, 0, 5, 1, 1);

        //            ins  br bz st fl fr fa fb a1 b1 st sc fc
        tab[0]  = mk(NOP,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tab[1]  = mk(LW5,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tab[2]  = mk(ADD6, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tab[3]  = mk(ADD6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        tab[4]  = mk(NOP,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        tab[5]  = mk(ADD5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tab[6]  = mk(SUB8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tab[7]  = mk(NOP,  0, 0, 0, 0, 0, 2, 2, 2, 2, 0, 1, 0);
        tab[8]  = mk(ADD5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tab[9]  = mk(NOP,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tab[10] = mk(SUB8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tab[11] = mk(NOP,  0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
        tab[12] = mk(LW0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tab[13] = mk(ADD9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tab[14] = mk(NOP,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tab[15] = mk(NOP,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tab[16] = mk(LW5,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tab[17] = mk(ADD6, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        tab[18] = mk(NOP,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        tab[19] = mk(LW5,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        tab[20] = mk(ADD6, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
        tab[21] = mk(ADD6, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2, 1, 1);
        tab[22] = mk(ADD6, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2, 1, 1);
        tab[23] = mk(ADD6, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 1, 1);
        tab[24] = mk(ADD6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1);
        tab[25] = mk(NOP,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 1);
        tab[26] = mk(ADD5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1);
        tab[27] = mk(SUB8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1);
        tab[28] = mk(NOP,  0, 1, 0, 0, 1, 2, 2, 2, 2, 0, 2, 1);
        tab[29] = mk(NOP,  0, 0, 0, 0, 0, 2, 2, 2, 2, 2, 2, 1);
        tab[30] = mk(NOP,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1);
        tab[31] = mk(ADD5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1);
        tab[32] = mk(ADD5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1);
        tab[33] = mk(SUB8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1);
        tab[34] = mk(NOP,  0, 0, 0, 0, 0, 2, 2, 2, 2, 0, 2, 1);
        tab[35] = mk(LW5,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1);
        tab[36] = mk(NOUSE,0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1);
        tab[37] = mk(LW5,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1);
        tab[38] = mk(SW,   0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 1);
        tab[39] = mk(SW,   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1);
        tab[40] = mk(NOP,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 1);

        rst = 1'b1;
        drive(NOP, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            string p;
            @(negedge clk);
            drive(tab[i].ins, tab[i].br, tab[i].busy);
            #1;
            p = $sformatf("v%0d", i);
            chk({p, " stall"},  32'(stall),  32'(tab[i].e_stall));
            chk({p, " bubble"}, 32'(bubble), 32'(tab[i].e_stall));
            chk({p, " flush"},  32'(flush),  32'(tab[i].e_flush));
            chk({p, " freeze"}, 32'(freeze), 32'(tab[i].e_freeze));
            chk({p, " fwd_a"},  32'(fwd_a),  32'(tab[i].e_fa));
            chk({p, " fwd_b"},  32'(fwd_b),  32'(tab[i].e_fb));
            chk({p, " fwd_a1"}, 32'(fwd_a1), 32'(tab[i].e_fa1));
            chk({p, " fwd_b1"}, 32'(fwd_b1), 32'(tab[i].e_fb1));
            chk({p, " state"},  32'(state),  32'(tab[i].e_st));
            chk({p, " scnt"},   32'(stall_cnt), tab[i].e_sc);
            chk({p, " fcnt"},   32'(flush_cnt), tab[i].e_fc);
        end

        // Dependent loads back to back: stall every other cycle.
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            drive(LWDEP, 0, 0);
            #1;
            chk($sformatf("sat k%0d stall", k),
                32'(stall), 32'(k % 2));
        end
        @(negedge clk);
        drive(NOP, 0, 0);
        #1;
        chk("sat scnt",  32'(stall_cnt),  303);
        chk("sat scnt1", 32'(stall_cnt1), 32'hFF);

        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            drive(NOP, 1, 0);
        end
        @(negedge clk);
        drive(NOP, 0, 0);
        #1;
        chk("sat fcnt",   32'(flush_cnt),  301);
        chk("sat fcnt1",  32'(flush_cnt1), 32'hFF);
        chk("sat scnt2",  32'(stall_cnt),  303);

        // Asynchronous reset in the middle of a load-use stall.
        @(negedge clk);
        drive(LW5, 0, 0);
        @(negedge clk);
        drive(ADD6, 0, 0);
        #1;
        chk("pre-rst stall", 32'(stall), 1);
        rst = 1'b1;
        ex_branch_taken = 1'b1;
        mem_busy = 1'b1;
        #1;
        chk_zero("mid-rst");
        @(negedge clk);
        drive(NOP, 0, 0);
        rst = 1'b0;
        #1;
        chk_zero("post-rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
